// File: rtl/dmem_param_pkg.sv
// Shared definitions for the byte-addressable data memory: access mode
// encodings and the image the storage array takes on while in reset.
package dmem_param_pkg;

  typedef enum logic [1:0] {
    RD_NONE    = 2'b00,
    RD_WORD    = 2'b01,
    RD_BYTE_ZX = 2'b10,
    RD_BYTE_SX = 2'b11
  } rd_mode_e;

  typedef enum logic [1:0] {
    WR_NONE = 2'b00,
    WR_WORD = 2'b01,
    WR_BYTE = 2'b10,
    WR_RSVD = 2'b11
  } wr_mode_e;

  localparam logic [15:0] RST_WORD0 = 16'h3142;
  localparam logic [15:0] RST_WORD1 = 16'h0000;
  localparam logic [15:0] RST_WORD2 = 16'h5678;
  localparam logic [15:0] RST_WORD3 = 16'hDEAD;
  localparam logic [15:0] RST_WORD4 = 16'hBEEF;

  // Reset contents of word idx; everything past word 4 clears to zero.
  function automatic logic [15:0] reset_word(input int idx);
    logic [15:0] val;
    case (idx)
      0:       val = RST_WORD0;
      1:       val = RST_WORD1;
      2:       val = RST_WORD2;
      3:       val = RST_WORD3;
      4:       val = RST_WORD4;
      default: val = 16'h0000;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/dmem_param_byte_lane_ext.sv
// Picks one byte out of the low 16 bits of a word and widens it to a full
// word, either with zero fill or by replicating the byte's top bit.
module byte_lane_ext #(
  parameter int DATA_W = 16
) (
  input  logic [15:0]       word,
  input  logic              lane,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] result
);

  logic [7:0] sel_byte;

  // Lane select followed by zero or sign extension.
  always_comb begin
    sel_byte = lane ? word[15:8] : word[7:0];
    if (sign_ext) begin
      result = {{(DATA_W-8){sel_byte[7]}}, sel_byte};
    end else begin
      result = {{(DATA_W-8){1'b0}}, sel_byte};
    end
  end

endmodule

// File: rtl/dmem_param.sv
// Single-cycle byte-addressable data memory built from a register array.
// Every accepted request answers one cycle later with rsp_valid; illegal
// requests answer with rsp_err, zero data, and bump a saturating counter.
module dmem_param
  import dmem_param_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [1:0]        mem_read,
  input  logic [1:0]        mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [7:0]        err_cnt
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  rd_mode_e          rd_mode;
  wr_mode_e          wr_mode;
  logic [IDX_W-1:0]  idx;
  logic              lane;
  logic              out_of_range;
  logic              fault;
  logic              do_write;
  logic [DATA_W-1:0] cur_word;
  logic [DATA_W-1:0] ext_data;
  logic [DATA_W-1:0] load_data;

  assign rd_mode  = rd_mode_e'(mem_read);
  assign wr_mode  = wr_mode_e'(mem_write);
  assign idx      = addr[IDX_W:1];
  assign lane     = addr[0];
  assign cur_word = mem[idx];

  // Any address bit above the word index means the byte address is past
  // the end of the array.
  generate
    if (ADDR_W > IDX_W + 1) begin : g_range
      assign out_of_range = |addr[ADDR_W-1:IDX_W+1];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  // Classify the request: conflicting modes, reserved store, misaligned
  // word access or out-of-range address all fault and touch nothing.
  always_comb begin
    fault = 1'b0;
    if ((rd_mode != RD_NONE) && (wr_mode != WR_NONE)) fault = 1'b1;
    if (wr_mode == WR_RSVD) fault = 1'b1;
    if (((rd_mode == RD_WORD) || (wr_mode == WR_WORD)) && lane) fault = 1'b1;
    if (out_of_range) fault = 1'b1;
    do_write = req_valid && !fault && (wr_mode != WR_NONE);
  end

  byte_lane_ext #(
    .DATA_W(DATA_W)
  ) u_byte_lane_ext (
    .word     (cur_word[15:0]),
    .lane     (lane),
    .sign_ext (rd_mode == RD_BYTE_SX),
    .result   (ext_data)
  );

  // Word loads take the whole entry, byte loads the extended lane.
  always_comb begin
    load_data = ext_data;
    if (rd_mode == RD_WORD) load_data = cur_word;
  end

  // Storage array: reset image on rst, stores land on the accepting edge so
  // a load on the very next edge already sees them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(reset_word(i));
      end
    end else if (do_write) begin
      if (wr_mode == WR_WORD) begin
        mem[idx] <= write_data;
      end else if (lane) begin
        mem[idx][15:8] <= write_data[7:0];
      end else begin
        mem[idx][7:0] <= write_data[7:0];
      end
    end
  end

  // Response register: one acknowledge per accepted request, load data only
  // changes on a good load (or clears on a fault), counter saturates at 255.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      rsp_valid <= req_valid;
      rsp_err   <= req_valid && fault;
      if (req_valid) begin
        if (fault) begin
          read_data <= '0;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end else if (rd_mode != RD_NONE) begin
          read_data <= load_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_param.sv
// Scoreboard bench for dmem_param: the driver queues the hand-computed
// response for each request, a negedge monitor pops and compares.
module tb_dmem_param;
  import dmem_param_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic [1:0]        mem_read = 2'b00;
  logic [1:0]        mem_write = 2'b00;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] write_data = '0;
  logic [DATA_W-1:0] read_data;
  logic              rsp_valid;
  logic              rsp_err;
  logic [7:0]        err_cnt;

  typedef struct {
    string       name;
    logic [15:0] data;
    logic        err;
    logic [7:0]  cnt;
  } expect_t;

  expect_t expQ[$];
  int checks = 0;
  int errors = 0;

  dmem_param #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .write_data(write_data),
    .read_data (read_data),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .err_cnt   (err_cnt)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
    end
  endtask

  // Present one request; once the accepting edge has passed, queue its answer.
  task automatic applyStimulus(input string name, input logic [1:0] rd,
                               input logic [1:0] wr, input logic [15:0] a,
                               input logic [15:0] wd, input logic [15:0] expData,
                               input logic expErr, input logic [7:0] expCnt);
    expect_t e;
    req_valid  = 1'b1;
    mem_read   = rd;
    mem_write  = wr;
    addr       = a;
    write_data = wd;
    @(posedge clk);
    #1;
    e.name = name;
    e.data = expData;
    e.err  = expErr;
    e.cnt  = expCnt;
    expQ.push_back(e);
    req_valid = 1'b0;
    mem_read  = 2'b00;
    mem_write = 2'b00;
  endtask

  // One cycle with req_valid low but arbitrary values on the other inputs.
  task automatic idleCycle(input logic [1:0] rd, input logic [1:0] wr,
                           input logic [15:0] a, input logic [15:0] wd);
    req_valid  = 1'b0;
    mem_read   = rd;
    mem_write  = wr;
    addr       = a;
    write_data = wd;
    @(posedge clk);
    #1;
    mem_read  = 2'b00;
    mem_write = 2'b00;
  endtask

  // Monitor: every response must match the oldest queued expectation, and
  // an expectation with no rsp_valid counts as a missing response.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious rsp_valid", 16'd1, 16'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput({e.name, " read_data"}, read_data, e.data);
          checkOutput({e.name, " rsp_err"}, {15'd0, rsp_err}, {15'd0, e.err});
          checkOutput({e.name, " err_cnt"}, {8'd0, err_cnt}, {8'd0, e.cnt});
        end
      end else if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput({e.name, " rsp_valid"}, 16'd0, 16'd1);
      end
    end
  end

  initial begin
    int cnt;
    $display("[TB] dmem_param scoreboard bench");

    #12;
    checkOutput("reset read_data", read_data, 16'h0000);
    checkOutput("reset rsp_valid", {15'd0, rsp_valid}, 16'd0);
    checkOutput("reset rsp_err", {15'd0, rsp_err}, 16'd0);
    checkOutput("reset err_cnt", {8'd0, err_cnt}, 16'd0);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus("rd word 0x6",   RD_WORD,    WR_NONE, 16'h0006, 16'h0000, 16'hDEAD, 1'b0, 8'd0);
    applyStimulus("wb 0x9",        RD_NONE,    WR_BYTE, 16'h0009, 16'h00A5, 16'hDEAD, 1'b0, 8'd0);
    applyStimulus("rd word 0x8",   RD_WORD,    WR_NONE, 16'h0008, 16'h0000, 16'hA5EF, 1'b0, 8'd0);
    applyStimulus("rd sx 0x7",     RD_BYTE_SX, WR_NONE, 16'h0007, 16'h0000, 16'hFFDE, 1'b0, 8'd0);
    applyStimulus("rd zx 0x7",     RD_BYTE_ZX, WR_NONE, 16'h0007, 16'h0000, 16'h00DE, 1'b0, 8'd0);
    applyStimulus("rd zx 0x0",     RD_BYTE_ZX, WR_NONE, 16'h0000, 16'h0000, 16'h0042, 1'b0, 8'd0);
    applyStimulus("rd sx 0x1",     RD_BYTE_SX, WR_NONE, 16'h0001, 16'h0000, 16'h0031, 1'b0, 8'd0);
    applyStimulus("rd sx 0x8",     RD_BYTE_SX, WR_NONE, 16'h0008, 16'h0000, 16'hFFEF, 1'b0, 8'd0);
    applyStimulus("noop",          RD_NONE,    WR_NONE, 16'h0000, 16'h0000, 16'hFFEF, 1'b0, 8'd0);
    applyStimulus("misaligned rd", RD_WORD,    WR_NONE, 16'h0003, 16'h0000, 16'h0000, 1'b1, 8'd1);
    applyStimulus("range wr",      RD_NONE,    WR_WORD, 16'h0080, 16'hFFFF, 16'h0000, 1'b1, 8'd2);
    applyStimulus("rd+wr",         RD_WORD,    WR_WORD, 16'h0004, 16'hFFFF, 16'h0000, 1'b1, 8'd3);
    applyStimulus("rsvd wr",       RD_NONE,    WR_RSVD, 16'h0004, 16'hFFFF, 16'h0000, 1'b1, 8'd4);
    applyStimulus("range rd",      RD_BYTE_ZX, WR_NONE, 16'h0080, 16'h0000, 16'h0000, 1'b1, 8'd5);
    applyStimulus("rd word 0x4",   RD_WORD,    WR_NONE, 16'h0004, 16'h0000, 16'h5678, 1'b0, 8'd5);
    applyStimulus("rd word 0x2",   RD_WORD,    WR_NONE, 16'h0002, 16'h0000, 16'h0000, 1'b0, 8'd5);
    applyStimulus("rd last word",  RD_WORD,    WR_NONE, 16'h007E, 16'h0000, 16'h0000, 1'b0, 8'd5);
    applyStimulus("wr last word",  RD_NONE,    WR_WORD, 16'h007E, 16'h9ABC, 16'h0000, 1'b0, 8'd5);
    applyStimulus("rd last again", RD_WORD,    WR_NONE, 16'h007E, 16'h0000, 16'h9ABC, 1'b0, 8'd5);
    applyStimulus("rd word 0x6 b", RD_WORD,    WR_NONE, 16'h0006, 16'h0000, 16'hDEAD, 1'b0, 8'd5);
    applyStimulus("wb lane0",      RD_NONE,    WR_BYTE, 16'h0000, 16'hFF77, 16'hDEAD, 1'b0, 8'd5);
    applyStimulus("rd word 0x0",   RD_WORD,    WR_NONE, 16'h0000, 16'h0000, 16'h3177, 1'b0, 8'd5);

    for (int i = 0; i < 300; i++) begin
      cnt = (6 + i > 255) ? 255 : 6 + i;
      applyStimulus("fault burst", RD_NONE, WR_RSVD, 16'h0004, 16'hFFFF, 16'h0000, 1'b1, 8'(cnt));
    end

    idleCycle(RD_NONE, WR_WORD, 16'h0000, 16'hFFFF);
    applyStimulus("rd after idle", RD_WORD,    WR_NONE, 16'h0000, 16'h0000, 16'h3177, 1'b0, 8'd255);
    applyStimulus("b2b wr",        RD_NONE,    WR_WORD, 16'h0004, 16'h1234, 16'h3177, 1'b0, 8'd255);
    applyStimulus("b2b rd",        RD_WORD,    WR_NONE, 16'h0004, 16'h0000, 16'h1234, 1'b0, 8'd255);
    applyStimulus("b2b wb",        RD_NONE,    WR_BYTE, 16'h0005, 16'h005A, 16'h1234, 1'b0, 8'd255);
    applyStimulus("b2b rd lane",   RD_WORD,    WR_NONE, 16'h0004, 16'h0000, 16'h5A34, 1'b0, 8'd255);
    idleCycle(RD_NONE, WR_NONE, 16'h0000, 16'h0000);

    rst = 1'b0;
    #1;
    checkOutput("mid reset read_data", read_data, 16'h0000);
    checkOutput("mid reset rsp_valid", {15'd0, rsp_valid}, 16'd0);
    checkOutput("mid reset err_cnt", {8'd0, err_cnt}, 16'd0);
    req_valid  = 1'b1;
    mem_write  = WR_WORD;
    addr       = 16'h000A;
    write_data = 16'hBBBB;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    mem_write = 2'b00;
    @(negedge clk);
    rst = 1'b1;

    applyStimulus("post rst 0x4",  RD_WORD,    WR_NONE, 16'h0004, 16'h0000, 16'h5678, 1'b0, 8'd0);
    applyStimulus("post rst 0xA",  RD_WORD,    WR_NONE, 16'h000A, 16'h0000, 16'h0000, 1'b0, 8'd0);
    applyStimulus("post rst 0x8",  RD_WORD,    WR_NONE, 16'h0008, 16'h0000, 16'hBEEF, 1'b0, 8'd0);
    idleCycle(RD_NONE, WR_NONE, 16'h0000, 16'h0000);
    idleCycle(RD_NONE, WR_NONE, 16'h0000, 16'h0000);

    checkOutput("scoreboard drained", 16'(expQ.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_param.md
DMEM_PARAM -- requirements
Module: dmem_param

Interface
REQ-001 Parameters SHALL be:
- DATA_W, 16, word width in bits; even, at least 16.
- ADDR_W, 16, byte-address width.
- DEPTH, 64, number of words; a power of two, at least 8.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present this cycle.
- mem_read  in  2  read mode: 00 none, 01 word, 10 byte zero-extended, 11 byte sign-extended.
- mem_write  in  2  write mode: 00 none, 01 word, 10 byte, 11 reserved.
- addr  in  ADDR_W  byte address.
- write_data  in  DATA_W  store data; the byte store uses bits [7:0].
- read_data  out  DATA_W  registered load result.
- rsp_valid  out  1  read_data valid; also high for a store acknowledge.
- rsp_err  out  1  the request that completed this cycle faulted.
- err_cnt  out  8  saturating fault counter.

Function
REQ-003 Addressing SHALL be byte-based.
- Word index is addr[log2(DEPTH):1].
- Byte lane is addr[0]: 0 selects bits [7:0], 1 selects bits [15:8].
REQ-004 A request SHALL be accepted on every rising edge with req_valid=1; the block has no backpressure.
REQ-005 Every accepted request SHALL produce rsp_valid=1 exactly one cycle later, and rsp_valid=0 in every other cycle.
REQ-006 A word read SHALL return the whole word: read_data is mem[index].
REQ-007 A byte read SHALL place the selected byte in read_data[7:0], with upper bits zero (mode 10) or copies of bit 7 of that byte (mode 11).
REQ-008 A word write SHALL update the whole word on the accepting edge.
REQ-009 A byte write SHALL update only the selected lane on the accepting edge; all other bits keep their values.
REQ-010 A read accepted in cycle N+1 SHALL return data written by a store accepted in cycle N; no stale data may be returned.
REQ-011 Fault conditions SHALL be:
- mem_read and mem_write both nonzero;
- mem_write=11;
- word access with addr[0]=1;
- addr at or above 2*DEPTH.
REQ-012 A faulting request SHALL:
- leave memory unchanged;
- give rsp_valid=1, rsp_err=1 and read_data=0 one cycle later;
- increment err_cnt, which saturates at 255.
REQ-013 A request with req_valid=1 and both modes 00 SHALL be a no-op: rsp_valid=1, rsp_err=0, read_data holds its previous value.
REQ-014 After a store, read_data SHALL hold its previous value; after a non-faulting read, rsp_err SHALL be 0.
REQ-015 With req_valid=0, mem_read, mem_write, addr and write_data SHALL be ignored, and memory and read_data SHALL be unchanged.

Reset
REQ-016 While rst=0 the block SHALL hold read_data=0, rsp_valid=0, rsp_err=0 and err_cnt=0, independent of clk.
REQ-017 While rst=0 memory SHALL be initialised to:
- word 0 = 0x3142;
- word 1 = 0x0000;
- word 2 = 0x5678;
- word 3 = 0xDEAD;
- word 4 = 0xBEEF;
- all other words = 0.
REQ-018 Reset asserted in the same cycle a request is accepted SHALL abort that request: no write occurs and no rsp_valid follows.
REQ-019 The first request SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-020 A shared package SHALL hold:
- the mem_read and mem_write mode encodings;
- the five reset-image constants.
REQ-021 Lane extraction and extension SHALL be one combinational sub-module, byte_lane_ext, selected by lane and sign mode.
REQ-022 Storage SHALL be a register array with asynchronous reset; no memory macro is used.

Verification
REQ-023 Release reset, then word read addr 0x0006 -> next cycle read_data=0xDEAD, rsp_valid=1, rsp_err=0.
REQ-024 Byte write 0x00A5 to addr 0x0009, then word read addr 0x0008 -> read_data=0xA5EF.
REQ-025 Byte read sign-extended at addr 0x0007 -> read_data=0xFFDE; byte read zero-extended at the same address -> read_data=0x00DE.
REQ-026 Word read addr 0x0003, then word write to addr 2*DEPTH -> both give rsp_err=1 with memory unchanged; 300 consecutive faults -> err_cnt=255.
REQ-027 Back-to-back requests: word write 0x1234 to addr 0x0004 in cycle N, word read addr 0x0004 in cycle N+1 -> read_data=0x1234 in cycle N+2.
REQ-028 Assert rst mid-stream after a write -> read_data=0 immediately, and word read addr 0x0004 after release returns 0x5678.
